// File: rtl/disp_pkg.sv
// Shared 7-segment code table, capture FSM encodings and an enable-pattern helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package disp_pkg;

  // Active-low segment patterns, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_t;

  // True when exactly one digit enable is driven low
  function automatic logic is_onehot_low(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) ||
           (an == 4'b1011) || (an == 4'b0111);
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Maps an active-low 7-segment pattern back to its hex value; hit=0 for non-digit patterns.
// Latency: combinational.
// Backpressure: none.
module sseg_to_hex
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] val
);

  // Table lookup against the shared code set
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (seg)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/disp_sseg_capture.sv
// Recovers the four hex digits and decimal points from a multiplexed an/sseg bus.
// Latency: pin change to output register update = 2 + STABLE_CYCLES + 1 cycles.
// Backpressure: none; free-running sampler. Optional DISP_CAPTURE_TIMEOUT_EN adds a capture timeout.
module disp_sseg_capture
  import disp_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       timeout
);

  localparam int unsigned   CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("STABLE_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [11:0]   sync1, sync2, prev;
  cap_state_t    state;
  logic [CW-1:0] cnt;
  logic [3:0]    hex_r [4];
  logic [3:0]    seen;
  logic          bus_chg, onehot, capture, hit;
  logic [3:0]    val, cap_bit;
  logic [1:0]    idx;

  // Two-stage synchronizer plus a one-cycle history for change detection; idle bus is all ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {an, sseg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  sseg_to_hex u_dec (
    .seg (sync2[6:0]),
    .hit (hit),
    .val (val)
  );

  // Change detection, capture strobe and target digit position
  always_comb begin
    bus_chg = (sync2 != prev);
    onehot  = is_onehot_low(sync2[11:8]);
    capture = (state == ST_SETTLE) && !bus_chg && (cnt == CNT_LAST);
    case (sync2[11:8])
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    cap_bit = (capture && hit) ? ~sync2[11:8] : 4'b0000;
  end

  // Stability FSM: any bus change restarts the count, so a change on the terminal cycle blocks capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (onehot) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (bus_chg) begin
            state <= onehot ? ST_SETTLE : ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (bus_chg) begin
            state <= onehot ? ST_SETTLE : ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISP_CAPTURE_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
`endif

  // Digit registers, seen-mask, frame/error pulses and the optional capture timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) hex_r[k] <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
`ifdef DISP_CAPTURE_TIMEOUT_EN
      tcnt        <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      seg_err <= 1'b0;
      if (capture) begin
        if (hit) begin
          hex_r[idx]       <= val;
          dp_out[idx]      <= ~sync2[7];
          digit_valid[idx] <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
          seg_err          <= 1'b1;
        end
      end
      // A full mask pulses frame_done one cycle after the completing capture
      if (seen == 4'b1111) begin
        frame_done <= 1'b1;
        seen       <= cap_bit;
      end else begin
        frame_done <= 1'b0;
        seen       <= seen | cap_bit;
      end
`ifdef DISP_CAPTURE_TIMEOUT_EN
      if (capture) begin
        tcnt    <= '0;
        timeout <= 1'b0;
      end else if (tcnt == TO_LAST) begin
        timeout     <= 1'b1;
        digit_valid <= '0;
        seen        <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
`endif
    end
  end

`ifndef DISP_CAPTURE_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  assign hex0 = hex_r[0];
  assign hex1 = hex_r[1];
  assign hex2 = hex_r[2];
  assign hex3 = hex_r[3];

endmodule

// File: tb/tb_disp_sseg_capture.sv
// Bench for disp_sseg_capture: directed scenarios plus random bus traffic against a run-length model.
// Latency: n/a.
// Backpressure: n/a.
module tb_disp_sseg_capture;

  localparam int S = 16;
`ifdef DISP_CAPTURE_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 2**20;
`endif
  localparam int T3_HOLD = (TO < 100) ? 40 : 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [7:0] sseg = 8'hFF;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out, digit_valid;
  logic       frame_done, seg_err, timeout;
  logic [26:0] got_v;

  always #5 clk = ~clk;

  disp_sseg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .digit_valid(digit_valid),
    .frame_done(frame_done), .seg_err(seg_err), .timeout(timeout)
  );

  assign got_v = {hex3, hex2, hex1, hex0, dp_out, digit_valid, frame_done, seg_err, timeout};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a capture happens when a one-hot value has been on the pins for
  // exactly S+1 consecutive samples, seen two sample edges earlier (synchronizer delay).
  logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [11:0] last_p;
  int          run;
  logic [11:0] d_val [3];
  int          d_run [3];
  logic [3:0]  m_hex [4];
  logic [3:0]  m_dp, m_valid, m_seen;
  logic        m_fd, m_err, m_tmo, m_fd_pend;
  int          since;
  int          fd_cnt = 0;
  int          err_cnt = 0;

  function automatic void model_reset();
    last_p = 12'hFFF;
    run    = 1000;
    for (int k = 0; k < 3; k++) begin
      d_val[k] = 12'hFFF;
      d_run[k] = 1000;
    end
    for (int k = 0; k < 4; k++) m_hex[k] = 4'h0;
    m_dp = 4'h0; m_valid = 4'h0; m_seen = 4'h0;
    m_fd = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_fd_pend = 1'b0;
    since = 0;
  endfunction

  function automatic void model_edge(input logic [11:0] p);
    logic [3:0] a;
    logic [6:0] seg;
    int         pos;
    int         v;
    bit         cap;
    run    = (p == last_p) ? ((run < 1000) ? run + 1 : 1000) : 1;
    last_p = p;
    d_val[2] = d_val[1]; d_val[1] = d_val[0]; d_val[0] = p;
    d_run[2] = d_run[1]; d_run[1] = d_run[0]; d_run[0] = run;
    a   = d_val[2][11:8];
    seg = d_val[2][6:0];
    cap = (d_run[2] == S + 1) && ($countones(~a) == 1);
    m_fd = m_fd_pend;
    m_fd_pend = 1'b0;
    m_err = 1'b0;
    if (cap) begin
      pos = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) pos = k;
      v = -1;
      for (int k = 0; k < 16; k++) if (codes[k] == seg) v = k;
      if (v >= 0) begin
        m_hex[pos]   = 4'(v);
        m_dp[pos]    = ~d_val[2][7];
        m_valid[pos] = 1'b1;
        m_seen[pos]  = 1'b1;
      end else begin
        m_valid[pos] = 1'b0;
        m_err        = 1'b1;
      end
      if (m_seen == 4'hF) begin
        m_fd_pend = 1'b1;
        m_seen    = 4'h0;
      end
    end
`ifdef DISP_CAPTURE_TIMEOUT_EN
    if (cap) begin
      since = 0;
      m_tmo = 1'b0;
    end else begin
      if (since < TO) since++;
      if (since >= TO) begin
        m_tmo   = 1'b1;
        m_valid = 4'h0;
        m_seen  = 4'h0;
      end
    end
`endif
  endfunction

  function automatic logic [26:0] model_out();
    return {m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_dp, m_valid, m_fd, m_err, m_tmo};
  endfunction

  // One clock: sample pins, advance the model, compare every output just after the edge
  task automatic step();
    logic [11:0] p;
    p = {an, sseg};
    @(posedge clk);
    model_edge(p);
    #1;
    check("cycle", 32'(got_v), 32'(model_out()));
    fd_cnt  += int'(frame_done);
    err_cnt += int'(seg_err);
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) step();
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] rs;
    int         sel;

    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 32'(got_v), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(4'hF, 8'hFF, 5);

    // Digit 0 held: capture lands exactly 19 cycles after the drive
    an = 4'b1110;
    sseg = 8'h81;
    repeat (18) step();
    check("t1_early", 32'(digit_valid), 32'h0);
    step();
    check("t1_valid", 32'(digit_valid), 32'h1);
    check("t1_hex0", 32'(hex0), 32'h0);
    check("t1_dp0", 32'(dp_out[0]), 32'h0);
    repeat (21) step();

    // Too short to capture
    hold(4'b1011, 8'h08, S - 2);
    hold(4'hF, 8'hFF, 40);
    check("t2_unchanged", 32'({hex2, dp_out[2], digit_valid[2]}), 32'h0);

    // Four digits, dp on position 1
    fd_cnt = 0;
    hold(4'b1110, 8'hCF, T3_HOLD);
    hold(4'b1101, 8'h12, T3_HOLD);
    hold(4'b1011, 8'h86, T3_HOLD);
    hold(4'b0111, 8'h88, T3_HOLD);
    check("t3_hex", 32'({hex3, hex2, hex1, hex0}), 32'hA321);
    check("t3_dp", 32'(dp_out), 32'b0010);
    check("t3_frame", 32'(fd_cnt), 32'd1);

    // Blank pattern on position 1
    err_cnt = 0;
    hold(4'b1101, 8'hFF, 40);
    check("t4_err", 32'(err_cnt), 32'd1);
    check("t4_valid1", 32'(digit_valid[1]), 32'h0);
    check("t4_hex1", 32'(hex1), 32'h2);

    // Two digits enabled: ignored
    err_cnt = 0;
    fd_cnt  = 0;
    hold(4'b1001, 8'h84, 100);
    check("t5_hex", 32'({hex3, hex2, hex1, hex0}), 32'hA321);
    check("t5_err", 32'(err_cnt), 32'd0);
    check("t5_frame", 32'(fd_cnt), 32'd0);

    // Random bus traffic
    repeat (300) begin
      sel = int'($urandom_range(0, 5));
      if (sel < 4) ra = ~(4'b0001 << sel);
      else if (sel == 4) ra = 4'hF;
      else ra = 4'($urandom);
      if ($urandom_range(0, 9) < 7) rs = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
      else rs = 8'($urandom);
      hold(ra, rs, int'($urandom_range(1, 40)));
    end

    // Reset in the middle of settling aborts everything
    hold(4'b0111, 8'h86, 10);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'(got_v), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) step();
    check("rst_recap", 32'({hex3, digit_valid}), 32'h38);

`ifdef DISP_CAPTURE_TIMEOUT_EN
    hold(4'b1110, 8'hCF, 30);
    hold(4'hF, 8'hFF, TO + 10);
    check("t6_tmo", 32'(timeout), 32'h1);
    check("t6_valid", 32'(digit_valid), 32'h0);
    hold(4'b1101, 8'hCF, 30);
    check("t6_clear", 32'(timeout), 32'h0);
`else
    check("no_tmo", 32'(timeout), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
